// File: rtl/shift_sequencer.sv
// shift_sequencer: 8-bit shift register with IDLE/SHIFT/DONE sequencing, selectable direction, fill source and shift count.
module shift_sequencer (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Load,
    input  logic [7:0] DataIn,
    input  logic       Dir,
    input  logic [3:0] Count,
    input  logic [1:0] Mode,
    input  logic       SerIn,
    input  logic       Abort,
    output logic [7:0] Q,
    output logic       SerOut,
    output logic       Busy,
    output logic       Done
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, nextState;
    logic [3:0] remaining, effCount;
    logic       dirLat, expelled, fill;
    logic [1:0] modeLat;
    logic [7:0] shifted;
    always_comb begin
        effCount  = (Count > 4'd8) ? 4'd8 : Count;
        expelled  = dirLat ? Q[7] : Q[0];
        fill      = (modeLat == 2'b00) ? 1'b0 :
                    (modeLat == 2'b01) ? 1'b1 :
                    (modeLat == 2'b10) ? expelled : SerIn;
        shifted   = dirLat ? {Q[6:0], fill} : {fill, Q[7:1]};
        nextState = state;
        case (state)
            IDLE:    nextState = Start ? ((effCount != 4'd0) ? SHIFT : DONE) : IDLE;
            SHIFT:   nextState = Abort ? IDLE : ((remaining == 4'd1) ? DONE : SHIFT);
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            Q         <= 8'h00;
            SerOut    <= 1'b0;
            remaining <= 4'd0;
            dirLat    <= 1'b0;
            modeLat   <= 2'b00;
        end else begin
            state <= nextState;
            if (state == IDLE && Start) begin
                dirLat    <= Dir;
                modeLat   <= Mode;
                remaining <= effCount;
                if (Load) Q <= DataIn;
            end else if (state == SHIFT && !Abort) begin
                Q         <= shifted;
                SerOut    <= expelled;
                remaining <= remaining - 4'd1;
            end
        end
    end
    // Status comes straight from the state register, never from inputs.
    assign Busy = (state != IDLE);
    assign Done = (state == DONE);
endmodule
